// File: rtl/subleq_mem_arbiter.sv
// Round-robin arbiter sharing one single-port program/data memory between the
// Subleq core and a host loader/debug port, with a host lock for atomic sequences.
module subleq_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,

    output logic              locked,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CORE = 2'd1,
        TAG_HOST = 2'd2
    } tag_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_last_host;
    logic              w_last_host_next;
    tag_t              r_rd_tag;
    tag_t              w_rd_tag_next;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_wdata_hold;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_host_rdata;

    logic              w_core_gnt;
    logic              w_host_gnt;
    logic              w_any_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;
    logic              w_core_rvalid;
    logic              w_host_rvalid;

    // Grant selection; reset forces both grants low whatever the requests say.
    always_comb begin
        w_core_gnt = 1'b0;
        w_host_gnt = 1'b0;
        if (reset) begin
            if (r_state == ST_LOCKED) begin
                w_host_gnt = host_req;
            end else if (core_req && host_req) begin
                w_core_gnt = r_last_host;
                w_host_gnt = !r_last_host;
            end else begin
                w_core_gnt = core_req;
                w_host_gnt = host_req;
            end
        end
    end

    assign w_any_gnt = w_core_gnt | w_host_gnt;

    always_comb begin
        w_state_next     = r_state;
        w_last_host_next = r_last_host;
        if (w_core_gnt) begin
            w_last_host_next = 1'b0;
        end else if (w_host_gnt) begin
            w_last_host_next = 1'b1;
        end
        case (r_state)
            ST_ARB: begin
                if (w_host_gnt && host_lock) begin
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // Leaving the lock hands the next contended cycle to the core.
                if (!host_lock) begin
                    w_state_next     = ST_ARB;
                    w_last_host_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_ARB;
            end
        endcase
    end

    always_comb begin
        w_addr  = r_addr_hold;
        w_we    = 1'b0;
        w_wdata = r_wdata_hold;
        if (w_core_gnt) begin
            w_addr  = core_addr;
            w_we    = core_we;
            w_wdata = core_wdata;
        end else if (w_host_gnt) begin
            w_addr  = host_addr;
            w_we    = host_we;
            w_wdata = host_wdata;
        end
    end

    always_comb begin
        w_rd_tag_next = TAG_NONE;
        if (w_core_gnt && !core_we) begin
            w_rd_tag_next = TAG_CORE;
        end else if (w_host_gnt && !host_we) begin
            w_rd_tag_next = TAG_HOST;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_ARB;
            r_last_host  <= 1'b1;
            r_rd_tag     <= TAG_NONE;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else begin
            r_state     <= w_state_next;
            r_last_host <= w_last_host_next;
            r_rd_tag    <= w_rd_tag_next;
            if (w_any_gnt) begin
                r_addr_hold  <= w_addr;
                r_wdata_hold <= w_wdata;
            end
        end
    end

    // The memory output is already registered, so the tagged port sees it
    // directly in the valid cycle and a copy is kept for the hold period.
    assign w_core_rvalid = (r_rd_tag == TAG_CORE);
    assign w_host_rvalid = (r_rd_tag == TAG_HOST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_core_rdata <= '0;
            r_host_rdata <= '0;
        end else begin
            if (w_core_rvalid) begin
                r_core_rdata <= mem_rdata;
            end
            if (w_host_rvalid) begin
                r_host_rdata <= mem_rdata;
            end
        end
    end

    assign core_gnt    = w_core_gnt;
    assign host_gnt    = w_host_gnt;
    assign core_rvalid = w_core_rvalid;
    assign host_rvalid = w_host_rvalid;
    assign core_rdata  = w_core_rvalid ? mem_rdata : r_core_rdata;
    assign host_rdata  = w_host_rvalid ? mem_rdata : r_host_rdata;
    assign locked      = (r_state == ST_LOCKED);
    assign mem_addr    = w_addr;
    assign mem_we      = w_we;
    assign mem_wdata   = w_wdata;

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// Bench for subleq_mem_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_subleq_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [9:0]  core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic        host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [9:0]  host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic        core_gnt, core_rvalid, host_gnt, host_rvalid, locked, mem_we;
    logic [31:0] core_rdata, host_rdata, mem_wdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_fail = 0;

    subleq_mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .locked(locked),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory: single port, registered read.
    logic [31:0] tb_mem [0:1023] = '{default: '0};
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        is_host;
        logic [31:0] data;
    } rd_t;

    rd_t         exp_q[$];
    rd_t         rd_e;
    logic [31:0] ref_mem [0:1023] = '{default: '0};
    logic        m_locked = 1'b0;
    logic        m_last_host = 1'b1;
    logic [9:0]  m_addr = '0;
    logic [31:0] m_core_rdata = '0, m_host_rdata = '0;
    logic        e_cg, e_hg, e_crv, e_hrv, e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_wd;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_core_gnt", core_gnt, 0);
            chk("rst_host_gnt", host_gnt, 0);
            chk("rst_core_rvalid", core_rvalid, 0);
            chk("rst_host_rvalid", host_rvalid, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_locked", locked, 0);
            chk("rst_core_rdata", core_rdata, 0);
            chk("rst_host_rdata", host_rdata, 0);
            m_locked = 1'b0;
            m_last_host = 1'b1;
            m_addr = '0;
            m_core_rdata = '0;
            m_host_rdata = '0;
            exp_q.delete();
        end else begin
            e_cg = 1'b0;
            e_hg = 1'b0;
            if (m_locked) e_hg = host_req;
            else if (core_req && host_req) begin
                if (m_last_host) e_cg = 1'b1; else e_hg = 1'b1;
            end else begin
                e_cg = core_req;
                e_hg = host_req;
            end
            e_crv = 1'b0;
            e_hrv = 1'b0;
            if (exp_q.size() > 0) begin
                rd_e = exp_q.pop_front();
                if (rd_e.is_host) begin e_hrv = 1'b1; m_host_rdata = rd_e.data; end
                else begin e_crv = 1'b1; m_core_rdata = rd_e.data; end
            end
            e_addr = m_addr;
            e_we = 1'b0;
            e_wd = '0;
            if (e_cg) begin e_addr = core_addr; e_we = core_we; e_wd = core_wdata; end
            else if (e_hg) begin e_addr = host_addr; e_we = host_we; e_wd = host_wdata; end

            chk("core_gnt", core_gnt, e_cg);
            chk("host_gnt", host_gnt, e_hg);
            chk("locked", locked, m_locked);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            if (e_we) chk("mem_wdata", mem_wdata, e_wd);
            chk("core_rvalid", core_rvalid, e_crv);
            chk("host_rvalid", host_rvalid, e_hrv);
            chk("core_rdata", core_rdata, m_core_rdata);
            chk("host_rdata", host_rdata, m_host_rdata);

            if (e_cg || e_hg) begin
                m_addr = e_addr;
                m_last_host = e_hg;
                if (e_we) ref_mem[e_addr] = e_wd;
                else begin
                    rd_e.is_host = e_hg;
                    rd_e.data = ref_mem[e_addr];
                    exp_q.push_back(rd_e);
                end
            end
            if (m_locked) begin
                if (!host_lock) begin m_locked = 1'b0; m_last_host = 1'b1; end
            end else if (e_hg && host_lock) m_locked = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic next(); @(posedge clk); #1; endtask
    task automatic mid(); @(negedge clk); endtask

    function automatic logic [9:0] rnd_addr();
        case ($urandom % 4)
            0: return 10'd1023;
            1: return 10'd0;
            default: return 10'($urandom % 16);
        endcase
    endfunction

    logic cg = 1'b0, hg = 1'b0;

    initial begin
        // Reset with both requesting
        core_req = 1'b1; host_req = 1'b1;
        mid();
        chk("lit_rst_core_gnt", core_gnt, 0);
        chk("lit_rst_host_gnt", host_gnt, 0);
        chk("lit_rst_mem_we", mem_we, 0);
        next(); reset = 1'b1;
        mid();
        chk("lit_first_core_gnt", core_gnt, 1);
        chk("lit_first_host_gnt", host_gnt, 0);

        // Preload mem[5]=0x11, mem[6]=0x22 from the host
        next(); core_req = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 10'd5; host_wdata = 32'h11;
        mid(); chk("lit_pre5_gnt", host_gnt, 1);
        next(); host_addr = 10'd6; host_wdata = 32'h22;
        mid();

        // Contention: core reads 5, host reads 6
        next(); core_req = 1'b1; core_we = 1'b0; core_addr = 10'd5; host_we = 1'b0; host_addr = 10'd6;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("lit_alt_core_gnt", core_gnt, (k % 2 == 0));
            chk("lit_alt_host_gnt", host_gnt, (k % 2 == 1));
            if (k % 2 == 1) begin
                chk("lit_alt_core_rvalid", core_rvalid, 1);
                chk("lit_alt_core_rdata", core_rdata, 32'h11);
            end else if (k > 0) begin
                chk("lit_alt_host_rvalid", host_rvalid, 1);
                chk("lit_alt_host_rdata", host_rdata, 32'h22);
            end
            next();
        end
        core_req = 1'b0; host_req = 1'b0;
        mid();
        chk("lit_alt_last_host_rvalid", host_rvalid, 1);
        chk("lit_alt_last_host_rdata", host_rdata, 32'h22);
        chk("lit_alt_last_core_rvalid", core_rvalid, 0);

        // Write-then-read at address 1023
        next(); host_req = 1'b1; host_we = 1'b1; host_addr = 10'd1023; host_wdata = 32'hDEADBEEF;
        mid(); chk("lit_wr1023_gnt", host_gnt, 1); chk("lit_wr1023_we", mem_we, 1);
        next(); host_req = 1'b0; core_req = 1'b1; core_we = 1'b0; core_addr = 10'd1023;
        mid(); chk("lit_rd1023_gnt", core_gnt, 1);
        next(); core_req = 1'b0;
        mid();
        chk("lit_rd1023_rvalid", core_rvalid, 1);
        chk("lit_rd1023_rdata", core_rdata, 32'hDEADBEEF);

        // Lock: host writes 0..3 while the core keeps requesting
        next(); core_req = 1'b1; core_addr = 10'd0; host_req = 1'b1; host_we = 1'b1; host_lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_addr = 10'(i); host_wdata = 32'hA0 + 32'(i);
            mid();
            chk("lit_lock_core_gnt", core_gnt, 0);
            chk("lit_lock_host_gnt", host_gnt, 1);
            if (i > 0) chk("lit_lock_locked", locked, 1);
            next();
        end
        host_req = 1'b0; host_lock = 1'b0;
        mid();
        next();
        mid();
        chk("lit_unlock_core_gnt", core_gnt, 1);
        chk("lit_unlock_locked", locked, 0);
        next(); core_req = 1'b0;
        mid();

        // Reset while a core read is in flight
        next(); core_req = 1'b1; core_we = 1'b0; core_addr = 10'd5;
        mid(); chk("lit_rstrd_gnt", core_gnt, 1);
        next(); core_req = 1'b0; reset = 1'b0;
        mid(); chk("lit_rstrd_rvalid_in", core_rvalid, 0);
        next(); mid();
        next(); reset = 1'b1;
        mid();
        chk("lit_rstrd_rvalid_after", core_rvalid, 0);
        chk("lit_rstrd_rdata_after", core_rdata, 0);

        // Idle: data from the last read stays on rdata
        next(); core_req = 1'b1; core_addr = 10'd6;
        mid();
        next(); core_req = 1'b0;
        mid(); chk("lit_idle_rd_rvalid", core_rvalid, 1); chk("lit_idle_rd_rdata", core_rdata, 32'h22);
        for (int i = 0; i < 10; i++) begin
            next(); mid();
            chk("lit_idle_mem_we", mem_we, 0);
            chk("lit_idle_gnt", {core_gnt, host_gnt}, 0);
            chk("lit_idle_rvalid", {core_rvalid, host_rvalid}, 0);
            chk("lit_idle_rdata", core_rdata, 32'h22);
        end

        // Randomized traffic; a requester left ungranted holds its request
        for (int cyc = 0; cyc < 4000; cyc++) begin
            next();
            if (!(core_req && !cg)) begin
                core_req = ($urandom % 3) != 0;
                core_we = $urandom % 2;
                core_addr = rnd_addr();
                core_wdata = $urandom;
            end
            if (!(host_req && !hg)) begin
                host_req = ($urandom % 3) != 0;
                host_we = $urandom % 2;
                host_addr = rnd_addr();
                host_wdata = $urandom;
            end
            if ($urandom % 8 == 0) host_lock = !host_lock;
            reset = ($urandom % 500) != 0;
            mid();
            cg = core_gnt;
            hg = host_gnt;
        end
        next(); reset = 1'b1; core_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
        mid(); next(); mid(); next(); mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/subleq_mem_arbiter.md
Name: subleq_mem_arbiter

Overview:
- Shares the single-port 1024x32 program/data memory between the Subleq core and a host loader/debug port.
- Round-robin arbitration per cycle; the host can lock the memory for atomic multi-word load or inspect sequences.
- Sits between the core's addr/writeEnable/writeData/readData interface and the memory array.
- Memory read is synchronous with 1-cycle latency; write commits on the posedge where granted.

Parameters:
ADDR_W, 10, memory address width (1024 words)
DATA_W, 32, data word width

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-low reset (0 = in reset)
core_req  in  1  core requests a memory access this cycle
core_we  in  1  1 = write, 0 = read (qualified by core_req)
core_addr  in  ADDR_W  core access address
core_wdata  in  DATA_W  core write data
core_gnt  out  1  core access accepted this cycle (combinational)
core_rvalid  out  1  core read data valid (registered, 1 cycle after granted read)
core_rdata  out  DATA_W  core read data
host_req  in  1  host requests a memory access
host_we  in  1  host write enable
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_lock  in  1  host requests exclusive ownership
host_gnt  out  1  host access accepted this cycle (combinational)
host_rvalid  out  1  host read data valid (registered)
host_rdata  out  DATA_W  host read data
locked  out  1  arbiter is in LOCKED state
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after read address

Behaviour:
- Reset (reset=0, async): state=ARB, last_owner=HOST, rd_tag=NONE. core_gnt=host_gnt=0, both rvalid=0, both rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, locked=0. Grants are forced to 0 while reset=0 regardless of req.
- States: ARB and LOCKED.
- ARB, one requester active: that requester is granted.
- ARB, both requesting: the requester that is not last_owner is granted (strict alternation).
- ARB, no request: no grant; mem_we=0, mem_addr holds its last value.
- last_owner updates on every granted cycle.
- ARB -> LOCKED at posedge when host_gnt=1 and host_lock=1.
- LOCKED: only the host is granted; core_gnt=0 even with core_req=1.
- LOCKED -> ARB at posedge when host_lock=0. The first ARB cycle after unlock uses last_owner=HOST, so a pending core request wins.
- Muxing (combinational): mem_addr, mem_we and mem_wdata follow the granted requester. Exactly one grant per cycle at most; gnt never asserts without the matching req.
- Write: mem_we=1 in the granted cycle; data commits at that posedge. No rvalid is generated for writes.
- Read: a granted read sets rd_tag=owner at the posedge. In the next cycle the tagged port gets rvalid=1 and rdata=mem_rdata, both registered and held until its next read completes. rvalid is a 1-cycle pulse per read.
- Back-to-back reads: pipelined, one result per cycle, results delivered in grant order even when alternating owners.
- Write then read of the same address on consecutive cycles (any owners): the read returns the new data.
- A requester not granted must hold req/addr/we/wdata stable until granted. The arbiter does not queue requests.
- host_lock asserted without host_req has no effect.
- Reset mid-operation: an in-flight read is dropped (no rvalid after reset release), LOCKED is exited, and an in-progress write is not guaranteed.
- Addresses are ADDR_W bits with no range check; the full 0..1023 range is legal.

Test Plan:
- Reset: assert reset=0 with both req=1 -> both gnt=0, rvalid=0, mem_we=0. Release reset -> first cycle core_gnt=1 (last_owner=HOST).
- Contention: core reads addr 5 and host reads addr 6 continuously, mem[5]=0x11, mem[6]=0x22 -> grants alternate C,H,C,H. core_rvalid pulses with 0x11 and host_rvalid pulses with 0x22, each one cycle after its grant.
- Write-then-read: host writes 0xDEADBEEF to 1023, then the core reads 1023 the next cycle -> core_rdata=0xDEADBEEF, core_rvalid=1 exactly one cycle after core_gnt.
- Lock: host writes addrs 0..3 with host_lock=1 while core_req=1 -> core_gnt=0 for all 4 cycles and locked=1. Drop host_lock -> the next cycle grants the core and locked=0.
- Reset mid-read: core read granted, reset=0 in the following cycle -> core_rvalid stays 0 through and after reset release.
- Idle: no requests for 10 cycles -> mem_we=0, no gnt, no rvalid, and the last read data is held on rdata.
